// File: rtl/sr_pkg.sv
// Shared types and the S/R resolution rule for the clocked SR flop bank.
package sr_pkg;

    localparam int SR_SET_DOM = 0;
    localparam int SR_RST_DOM = 1;
    localparam int SR_HOLD    = 2;
    localparam int SR_TOGGLE  = 3;

    // Pair layout is {s, r}.
    typedef logic [1:0] sr_pair_t;

    function automatic logic resolve(input int mode, input sr_pair_t pair, input logic q);
        logic nq;
        nq = q;
        case (pair)
            2'b10: nq = 1'b1;
            2'b01: nq = 1'b0;
            2'b11: begin
                case (mode)
                    SR_SET_DOM: nq = 1'b1;
                    SR_RST_DOM: nq = 1'b0;
                    SR_TOGGLE:  nq = ~q;
                    default:    nq = q;
                endcase
            end
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR storage channel: optional persistence filter, resolution, edge pulses, sticky conflict.
module sr_cell
    import sr_pkg::*;
#(
    parameter int   MODE          = SR_SET_DOM,
    parameter int   FILTER_CYCLES = 0,
    parameter logic INIT          = 1'b0
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  sr_pair_t pair_i,
    input  logic     clr_conflict_i,
    output logic     q_o,
    output logic     rise_o,
    output logic     fall_o,
    output logic     conflict_o
);

    logic apply;
    logic q_q, q_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic conflict_q, conflict_d;

    generate
        if (FILTER_CYCLES == 0) begin : g_nofilt
            assign apply = 1'b1;
        end else begin : g_filt
            localparam int KW = $clog2(FILTER_CYCLES + 1);
            localparam logic [KW-1:0] N_K = KW'(FILTER_CYCLES);

            sr_pair_t      cand_q, cand_d;
            logic [KW-1:0] cnt_q, cnt_d;

            // Count saturates at N so a held pair keeps being applied every edge.
            always_comb begin
                cand_d = cand_q;
                cnt_d  = cnt_q;
                apply  = 1'b0;
                if (pair_i != cand_q) begin
                    cand_d = pair_i;
                    cnt_d  = '0;
                end else begin
                    if (cnt_q != N_K) cnt_d = cnt_q + KW'(1);
                    apply = (cnt_d == N_K);
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cand_q <= 2'b00;
                    cnt_q  <= N_K;
                end else begin
                    cand_q <= cand_d;
                    cnt_q  <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        q_d        = q_q;
        conflict_d = conflict_q;
        if (apply) q_d = resolve(MODE, pair_i, q_q);
        if (apply && (pair_i == 2'b11)) begin
            conflict_d = 1'b1;
        end else if (clr_conflict_i) begin
            conflict_d = 1'b0;
        end
        rise_d = q_d & ~q_q;
        fall_d = ~q_d & q_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q        <= INIT;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            conflict_q <= conflict_d;
        end
    end

    assign q_o        = q_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign conflict_o = conflict_q;

endmodule

// File: rtl/sr_flop_bank.sv
// WIDTH independent clocked SR channels; wiring plus the complementary output.
module sr_flop_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               MODE          = SR_SET_DOM,
    parameter int               FILTER_CYCLES = 0,
    parameter logic [WIDTH-1:0] INIT          = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] conflict
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            sr_cell #(
                .MODE          (MODE),
                .FILTER_CYCLES (FILTER_CYCLES),
                .INIT          (INIT[i])
            ) u_cell (
                .clk_i          (clk),
                .rst_i          (rst),
                .pair_i         ({s[i], r[i]}),
                .clr_conflict_i (clr_conflict[i]),
                .q_o            (q[i]),
                .rise_o         (rise[i]),
                .fall_o         (fall[i]),
                .conflict_o     (conflict[i])
            );
        end
    endgenerate

    assign qbar = ~q;

endmodule

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Parametrised, clocked successor to the gate-level SR latch: WIDTH independent SR storage channels in one synchronous block.
- Adds a selectable S=R=1 resolution mode, an optional per-channel glitch filter, edge-event pulses and sticky conflict flags.
- Guarantees q/qbar complementarity at all times, including the S=R=1 case.
- Sits between raw control/status strobes and consumers that need clean held levels plus change events.

Parameters:
- WIDTH, 8, number of independent channels (1..32).
- MODE, 0, S=R=1 resolution: 0 set-dominant, 1 reset-dominant, 2 hold, 3 toggle.
- FILTER_CYCLES, 0, extra consecutive samples an {s,r} pair must persist before it is applied (0 = no filter; valid range 0..255).
- INIT, {WIDTH{1'b0}}, reset value of q.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- s  input  WIDTH  per-channel set request, sampled on clk.
- r  input  WIDTH  per-channel reset request, sampled on clk.
- clr_conflict  input  WIDTH  write-1-to-clear for conflict bits.
- q  output  WIDTH  stored state.
- qbar  output  WIDTH  always exactly ~q.
- rise  output  WIDTH  one-cycle pulse: q went 0->1 on this edge.
- fall  output  WIDTH  one-cycle pulse: q went 1->0 on this edge.
- conflict  output  WIDTH  sticky: an S=R=1 pair was applied.

Behaviour:
- Reset (asynchronous, immediate on rst=1): q=INIT, qbar=~INIT, rise=0, fall=0, conflict=0, filter candidate=00, filter count=FILTER_CYCLES. Any in-progress filter history is discarded.
- Per channel, each rising edge: sample pair P={s,r}.
- Filter, FILTER_CYCLES=0: P is applied on the edge it is sampled (q visible one edge after inputs are set up).
- Filter, N=FILTER_CYCLES>0:
  - State: candidate C (2 bits) and count K, saturating at N; K is $clog2(N+1) bits wide.
  - If P!=C: C<=P, K<=0, nothing applied.
  - If P==C: K<=min(K+1,N); P is applied when the new K equals N.
  - A pair is therefore applied on the (N+1)th consecutive identical sample, then re-applied on every following edge while it is held.
- Applied pair actions:
  - 00: hold.
  - 10: q<=1.
  - 01: q<=0.
  - 11: MODE 0 q<=1; MODE 1 q<=0; MODE 2 hold; MODE 3 q<=~q, toggling every applied edge.
- conflict[i]: set on any edge where pair 11 is applied, in every MODE. Cleared when clr_conflict[i]=1 at an edge. If set and clear occur on the same edge, set wins. A clear with no pending conflict has no effect.
- rise/fall:
  - Registered alongside q: rise = q_next & ~q, fall = ~q_next & q.
  - High for exactly the first cycle q shows its new value.
  - Never both high on one channel.
- qbar: combinational ~q; never equal to q, never X once out of reset.
- Channels are fully independent; no cross-channel interaction.
- Latency: the pair sampled at edge k (with filter satisfied) appears on q after edge k.

Decomposition:
- Package sr_pkg:
  - Mode constants SR_SET_DOM=0, SR_RST_DOM=1, SR_HOLD=2, SR_TOGGLE=3.
  - 2-bit sr_pair_t typedef.
  - A pure function resolve(mode, pair, q) returning next q.
- One sub-module sr_cell:
  - Single channel: filter, resolve, q, rise/fall, conflict.
  - Same parameters minus WIDTH, with INIT reduced to 1 bit.
  - Instantiated WIDTH times in a generate loop.
- The top level is wiring only, plus the qbar assignment.

Test Plan:
- WIDTH=4, MODE=0, FILTER=0, INIT=4'b0101; release rst, drive s=4'b0010 one cycle -> q=4'b0111, qbar=4'b1000, rise=4'b0010 for exactly one cycle, fall=0.
- MODE 0/1/2, q=0, drive s=r=1 on ch0 one edge -> q[0]=1/0/0 respectively; conflict[0]=1 stays high; clr_conflict[0] pulse -> conflict[0]=0.
- MODE=3, q[0]=0, hold s=r=1 for 4 edges -> q[0] sequence 1,0,1,0; rise and fall alternate each cycle; conflict[0]=1.
- FILTER_CYCLES=2, s[0]=1 for 2 edges then 0 -> q unchanged; s[0]=1 for 3 edges -> q[0]=1 after the 3rd edge; a 1-cycle r glitch inside the run restarts the count.
- Same-edge conflict set and clr_conflict -> conflict remains 1.
- Assert rst asynchronously mid-filter with q=4'b1111 -> q=INIT immediately (before the next clk edge); after release, a pair held only N-1 further edges is not applied.
